mp_calc_seq: RTL and testbench
==============================

// Module: mp_calc_seq
// PURPOSE
//  Parametrised multi-precision calculator sequencer: executes one real or complex
//  operation per start/done handshake on WIDTH-bit unsigned operands (a,b,c,d).
//  Complex ops are decomposed into micro-ops (mul/add/sub/div) run on one shared
//  internal datapath, each micro-op held STEP_CYCLES cycles (multicycle unit model).
//  Sits between the operand/opcode register bank and the result register file.
// PARAMETERS
//  WIDTH        16  operand/result width, >=4, power of two
//  STEP_CYCLES  6   cycles per micro-op, >=1
// PORTS
//  clk     in   1      clock, rising edge
//  reset   in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only while busy=0
//  opcode  in   4      operation select, captured with start
//  a,b,c,d in   WIDTH  operands; complex view x=a+jb, y=c+jd; captured with start
//  busy    out  1      operation in progress
//  done    out  1      one-cycle completion pulse
//  err     out  1      status of last op: div-by-zero or illegal opcode; valid with done
//  out     out  WIDTH  real / scalar result, held until next done
//  im      out  WIDTH  imaginary result (0 for scalar ops), held until next done
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, err=0, out=0, im=0, all counters 0.
//  FSM: IDLE -(start)-> EXEC -(last micro-op ends)-> IDLE with done pulse.
//  IDLE: start=1 at edge k latches opcode/a..d; busy=1 from k+1.
//  EXEC: micro-step index s, step counter 0..STEP_CYCLES-1; result of step s
//   written to temp regs on its final cycle; s advances.
//  Completion: out/im/err updated, busy->0, done=1 for one cycle; done rises at
//   edge k+N*STEP_CYCLES (N = micro-op count). start during done cycle accepted.
//  start while busy=1: ignored, captured operands unaffected by input changes.
//  Opcodes (all arithmetic modulo 2^WIDTH, unsigned, no saturation):
//   0 ADD  out=a+b             N=1   | 1 SUB  out=a-b              N=1
//   2 MUL  out=(a*b)[W-1:0]    N=1   | 3 DIV  out=a/b              N=1
//   4 CADD out=a+c, im=b+d     N=2   | 5 CSUB out=a-c, im=b-d      N=2
//   6 CMUL out=ac-bd, im=ad+bc N=6  (ac,bd,sub,ad,bc,add)
//   7 CDIV den=cc+dd; out=(ac+bd)/den, im=(bc-ad)/den  N=11
//   8 ROL  out=a rotl (b mod WIDTH) N=1 | 9 ROR out=a rotr (b mod WIDTH) N=1
//   10-15  illegal: N=1, out=0, im=0, err=1
//  Products truncated to WIDTH before use in later micro-ops.
//  Divide by zero (b=0 or den=0): quotient=all ones, op continues, err=1 at done.
//  Reset mid-operation: abort immediately, no done, outputs to reset values.
// CONFIGURATION
//  MPC_DIV_EN defined: opcodes 3 and 7 implemented as above.
//  MPC_DIV_EN undefined: no divider synthesised; opcodes 3 and 7 treated as
//   illegal (N=1, out=0, im=0, err=1).
// TESTING (WIDTH=16, STEP_CYCLES=6, MPC_DIV_EN defined)
//  ADD a=0x1234 b=0x0F0F -> done 6 cycles after start edge, out=0x2143, im=0, err=0.
//  CMUL a=3 b=4 c=5 d=2 -> done after 36 cycles, out=7, im=0x001A; start pulses
//   while busy ignored, result unchanged.
//  CDIV a=10 b=20 c=1 d=2 -> done after 66 cycles, out=10, im=0, err=0;
//   DIV a=100 b=0 -> out=0xFFFF, err=1.
//  ROR a=0x0001 b=1 -> out=0x8000; ROL a=0x8001 b=20 -> out=0x0018.
//  Opcode 0xA -> done after 6 cycles, out=0, im=0, err=1; back-to-back start in
//   done cycle accepted (busy=1 next cycle).
//  reset asserted 10 cycles into CMUL -> busy=0, out=0, im=0, no done pulse;
//   MPC_DIV_EN undefined: opcode 3 -> err=1, out=0.

Source files
------------

// File: rtl/mp_calc_seq.sv
// mp_calc_seq: multi-precision real/complex calculator sequencer on a shared micro-op datapath.
// Define MPC_DIV_EN to build the divider (opcodes 3 DIV and 7 CDIV); otherwise those opcodes are illegal.
module mp_calc_seq #(
  parameter int WIDTH       = 16,
  parameter int STEP_CYCLES = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] im
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_CADD = 4'd4;
  localparam logic [3:0] OP_CSUB = 4'd5;
  localparam logic [3:0] OP_CMUL = 4'd6;
  localparam logic [3:0] OP_CDIV = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;

  localparam logic [2:0] U_ADD = 3'd0;
  localparam logic [2:0] U_SUB = 3'd1;
  localparam logic [2:0] U_MUL = 3'd2;
  localparam logic [2:0] U_DIV = 3'd3;
  localparam logic [2:0] U_ROL = 3'd4;
  localparam logic [2:0] U_ROR = 3'd5;

  localparam logic [2:0] S_A  = 3'd0;
  localparam logic [2:0] S_B  = 3'd1;
  localparam logic [2:0] S_C  = 3'd2;
  localparam logic [2:0] S_D  = 3'd3;
  localparam logic [2:0] S_T0 = 3'd4;
  localparam logic [2:0] S_T1 = 3'd5;
  localparam logic [2:0] S_T2 = 3'd6;
  localparam logic [2:0] S_T3 = 3'd7;

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  typedef struct packed {
    logic [2:0] u;
    logic [2:0] x;
    logic [2:0] y;
    logic [1:0] dst;
  } uinst_t;

  function automatic uinst_t mk(
    input logic [2:0] u,
    input logic [2:0] x,
    input logic [2:0] y,
    input logic [1:0] dst
  );
    uinst_t r;
    r.u   = u;
    r.x   = x;
    r.y   = y;
    r.dst = dst;
    return r;
  endfunction

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [WIDTH-1:0] r_t [4];
  logic [3:0]       r_step;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;

  uinst_t           w_ui;
  logic             w_legal;
  logic [3:0]       w_n;
  logic [WIDTH-1:0] w_src [8];
  logic [WIDTH-1:0] w_x, w_y, w_res;
  logic [LW-1:0]    w_sh;
  logic             w_dz;
  logic [WIDTH-1:0] w_tn [4];
  logic [WIDTH-1:0] w_out, w_im;
  logic             w_err;

  // Micro-program: one instruction per (opcode, step).
  always_comb begin
    w_ui    = mk(U_ADD, S_A, S_B, 2'd0);
    w_legal = 1'b1;
    w_n     = 4'd1;
    case (r_op)
      OP_ADD: w_ui = mk(U_ADD, S_A, S_B, 2'd0);
      OP_SUB: w_ui = mk(U_SUB, S_A, S_B, 2'd0);
      OP_MUL: w_ui = mk(U_MUL, S_A, S_B, 2'd0);
`ifdef MPC_DIV_EN
      OP_DIV: w_ui = mk(U_DIV, S_A, S_B, 2'd0);
`else
      OP_DIV: w_legal = 1'b0;
`endif
      OP_CADD: begin
        w_n = 4'd2;
        if (r_step == 4'd0) w_ui = mk(U_ADD, S_A, S_C, 2'd0);
        else                w_ui = mk(U_ADD, S_B, S_D, 2'd1);
      end
      OP_CSUB: begin
        w_n = 4'd2;
        if (r_step == 4'd0) w_ui = mk(U_SUB, S_A, S_C, 2'd0);
        else                w_ui = mk(U_SUB, S_B, S_D, 2'd1);
      end
      OP_CMUL: begin
        w_n = 4'd6;
        case (r_step)
          4'd0:    w_ui = mk(U_MUL, S_A,  S_C,  2'd0);
          4'd1:    w_ui = mk(U_MUL, S_B,  S_D,  2'd1);
          4'd2:    w_ui = mk(U_SUB, S_T0, S_T1, 2'd0);
          4'd3:    w_ui = mk(U_MUL, S_A,  S_D,  2'd1);
          4'd4:    w_ui = mk(U_MUL, S_B,  S_C,  2'd2);
          default: w_ui = mk(U_ADD, S_T1, S_T2, 2'd1);
        endcase
      end
`ifdef MPC_DIV_EN
      OP_CDIV: begin
        w_n = 4'd11;
        case (r_step)
          4'd0:    w_ui = mk(U_MUL, S_C,  S_C,  2'd0);
          4'd1:    w_ui = mk(U_MUL, S_D,  S_D,  2'd1);
          4'd2:    w_ui = mk(U_ADD, S_T0, S_T1, 2'd0);
          4'd3:    w_ui = mk(U_MUL, S_A,  S_C,  2'd1);
          4'd4:    w_ui = mk(U_MUL, S_B,  S_D,  2'd2);
          4'd5:    w_ui = mk(U_ADD, S_T1, S_T2, 2'd1);
          4'd6:    w_ui = mk(U_MUL, S_B,  S_C,  2'd2);
          4'd7:    w_ui = mk(U_MUL, S_A,  S_D,  2'd3);
          4'd8:    w_ui = mk(U_SUB, S_T2, S_T3, 2'd2);
          4'd9:    w_ui = mk(U_DIV, S_T1, S_T0, 2'd1);
          default: w_ui = mk(U_DIV, S_T2, S_T0, 2'd2);
        endcase
      end
`else
      OP_CDIV: w_legal = 1'b0;
`endif
      OP_ROL: w_ui = mk(U_ROL, S_A, S_B, 2'd0);
      OP_ROR: w_ui = mk(U_ROR, S_A, S_B, 2'd0);
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_src[0] = r_a;
    w_src[1] = r_b;
    w_src[2] = r_c;
    w_src[3] = r_d;
    w_src[4] = r_t[0];
    w_src[5] = r_t[1];
    w_src[6] = r_t[2];
    w_src[7] = r_t[3];
    w_x      = w_src[w_ui.x];
    w_y      = w_src[w_ui.y];
  end

  // Shared datapath; products keep only the low WIDTH bits.
  always_comb begin
    w_dz  = 1'b0;
    w_sh  = w_y[LW-1:0];
    w_res = '0;
    case (w_ui.u)
      U_ADD: w_res = w_x + w_y;
      U_SUB: w_res = w_x - w_y;
      U_MUL: w_res = w_x * w_y;
      U_ROL: w_res = (w_x << w_sh) | (w_x >> (WIDTH - int'(w_sh)));
      U_ROR: w_res = (w_x >> w_sh) | (w_x << (WIDTH - int'(w_sh)));
`ifdef MPC_DIV_EN
      U_DIV: begin
        if (w_y == '0) begin
          w_res = '1;
          w_dz  = 1'b1;
        end else begin
          w_res = w_x / w_y;
        end
      end
`endif
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_tn           = r_t;
    w_tn[w_ui.dst] = w_res;
    w_out          = '0;
    w_im           = '0;
    if (w_legal) begin
      case (r_op)
        OP_CADD, OP_CSUB, OP_CMUL: begin
          w_out = w_tn[0];
          w_im  = w_tn[1];
        end
        OP_CDIV: begin
          w_out = w_tn[1];
          w_im  = w_tn[2];
        end
        default: w_out = w_tn[0];
      endcase
    end
    w_err = !w_legal || r_dz || w_dz;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      for (int i = 0; i < 4; i++) r_t[i] <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      out     <= '0;
      im      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= opcode;
            r_a     <= a;
            r_b     <= b;
            r_c     <= c;
            r_d     <= d;
            r_step  <= '0;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
            busy    <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        default: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_t   <= w_tn;
            if (w_dz) r_dz <= 1'b1;
            if (r_step == w_n - 4'd1) begin
              out     <= w_out;
              im      <= w_im;
              err     <= w_err;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_step  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_step <= r_step + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_calc_seq.sv
// tb_mp_calc_seq: directed and randomized checks of mp_calc_seq against a behavioural model.
// Model honours MPC_DIV_EN the same way as the design build.
module tb_mp_calc_seq;

  localparam int W  = 16;
  localparam int SC = 6;
`ifdef MPC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] a, b, c, d;
  logic         busy, done, err;
  logic [W-1:0] out, im;

  int n_tests = 0;
  int n_fail  = 0;

  mp_calc_seq #(.WIDTH(W), .STEP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .err(err), .out(out), .im(im)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] qdiv(input logic [W-1:0] n, input logic [W-1:0] dv, inout bit e);
    if (dv == 0) begin
      e = 1'b1;
      return {W{1'b1}};
    end
    return n / dv;
  endfunction

  function automatic void model(
    input  logic [3:0]   op,
    input  logic [W-1:0] x, y, z, w,
    output logic [W-1:0] o, i,
    output bit           e,
    output int           n
  );
    logic [W-1:0] ac, bd, ad, bc, den;
    int sh;
    o = 0; i = 0; e = 1'b0; n = 1;
    ac = x * z; bd = y * w; ad = x * w; bc = y * z;
    sh = int'(y) % W;
    case (op)
      0: o = x + y;
      1: o = x - y;
      2: o = x * y;
      3: if (DIV_EN) o = qdiv(x, y, e); else e = 1'b1;
      4: begin n = 2; o = x + z; i = y + w; end
      5: begin n = 2; o = x - z; i = y - w; end
      6: begin n = 6; o = ac - bd; i = ad + bc; end
      7: begin
        if (DIV_EN) begin
          n = 11;
          den = z * z + w * w;
          o = qdiv(ac + bd, den, e);
          i = qdiv(bc - ad, den, e);
        end else e = 1'b1;
      end
      8: for (int j = 0; j < W; j++) o[(j + sh) % W] = x[j];
      9: for (int j = 0; j < W; j++) o[j] = x[(j + sh) % W];
      default: e = 1'b1;
    endcase
  endfunction

  // Start an op now; leaves the caller inside the done cycle.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, y, z, w, input bit noise);
    logic [W-1:0] eo, ei;
    bit ee, got;
    int en, cyc;
    model(op, x, y, z, w, eo, ei, ee, en);
    opcode = op; a = x; b = y; c = z; d = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_set", 32'(busy), 32'd1);
    chk("done_low", 32'(done), 32'd0);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 400) begin
      if (noise) begin
        a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
        opcode = 4'($urandom); start = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      chk("timeout", 32'd0, 32'd1);
      return;
    end
    chk($sformatf("lat_op%0d", op), 32'(cyc), 32'(en * SC));
    chk($sformatf("out_op%0d", op), 32'(out), 32'(eo));
    chk($sformatf("im_op%0d", op), 32'(im), 32'(ei));
    chk($sformatf("err_op%0d", op), 32'(err), 32'(ee));
    chk("busy_clr", 32'(busy), 32'd0);
  endtask

  initial begin
    bit saw;
    reset = 1'b1; start = 1'b0; opcode = 0; a = 0; b = 0; c = 0; d = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_im", 32'(im), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(4'd0, 16'h1234, 16'h0F0F, 16'h0, 16'h0, 1'b0);
    chk("add_const", 32'(out), 32'h2143);
    do_op(4'd6, 16'd3, 16'd4, 16'd5, 16'd2, 1'b1);
    chk("cmul_const", {16'(out), 16'(im)}, {16'd7, 16'h001A});
    do_op(4'd7, 16'd10, 16'd20, 16'd1, 16'd2, 1'b0);
    do_op(4'd3, 16'd100, 16'd0, 16'd0, 16'd0, 1'b0);
    do_op(4'd9, 16'h0001, 16'd1, 16'd0, 16'd0, 1'b0);
    chk("ror_const", 32'(out), 32'h8000);
    do_op(4'd8, 16'h8001, 16'd20, 16'd0, 16'd0, 1'b0);
    chk("rol_const", 32'(out), 32'h0018);
    do_op(4'hA, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    chk("ill_err", 32'(err), 32'd1);
    do_op(4'd1, 16'h0005, 16'h0007, 16'd0, 16'd0, 1'b0);
    do_op(4'd5, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
    do_op(4'd2, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 1'b0);
    do_op(4'd7, 16'd9, 16'd9, 16'd0, 16'd0, 1'b0);

    for (int k = 0; k < 120; k++) begin
      logic [W-1:0] x, y, z, w;
      x = W'($urandom); y = W'($urandom); z = W'($urandom); w = W'($urandom);
      if ($urandom_range(0, 3) == 0) y = W'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin z = 0; w = W'($urandom_range(0, 1)); end
      do_op(4'($urandom), x, y, z, w, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);
      end
    end

    do_op(4'd0, 16'h00F0, 16'h0F00, 16'd0, 16'd0, 1'b0);
    opcode = 4'd6; a = 16'd3; b = 16'd4; c = 16'd5; d = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_im", 32'(im), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    saw = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    chk("mid_rst_nodone", 32'(saw), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
